// File: rtl/reg_stream_pack.sv
// Width up-converter: packs RATIO little-endian WIDTH-bit beats into one registered output word.
// Optional early completion on S_WLAST is enabled with the REG_STREAM_PACK_LAST_EN macro.
module reg_stream_pack #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned RATIO = 4
) (
  input  logic                     CLK_I,
  input  logic                     RST_I,
  input  logic                     S_WVALID,
  output logic                     S_WREADY,
  input  logic [WIDTH-1:0]         S_WDATA,
  input  logic                     S_WLAST,
  output logic                     M_WVALID,
  input  logic                     M_WREADY,
  output logic [WIDTH*RATIO-1:0]   M_WDATA,
  output logic [RATIO-1:0]         M_WKEEP
);

  localparam int unsigned CntW  = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned WordW = WIDTH * RATIO;
  localparam logic [CntW-1:0] LastIdx = CntW'(RATIO - 1);

  typedef enum logic [1:0] {
    StEmpty,
    StFill,
    StLastLane
  } pack_state_e;

  pack_state_e pack_state;

  logic [WordW-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WordW-1:0] out_reg_q, out_reg_d;
  logic [RATIO-1:0] out_keep_q, out_keep_d;
  logic             out_vld_q, out_vld_d;

  logic             in_hs;
  logic             out_hs;
  logic             last_in;
  logic             complete;
  logic [WordW-1:0] merged;
  logic [RATIO-1:0] keep_mask;

`ifdef REG_STREAM_PACK_LAST_EN
  assign last_in = S_WLAST;
`else
  // Port kept for a pin-compatible netlist; ignored in this build.
  logic unused_last;
  assign unused_last = S_WLAST;
  assign last_in     = 1'b0;
`endif

  // Non-completing beats also stall on a blocked output so acc and out_reg stay independent.
  assign S_WREADY = ~RST_I & (~out_vld_q | M_WREADY);
  assign in_hs    = S_WVALID & S_WREADY;
  assign out_hs   = out_vld_q & M_WREADY;

  assign M_WVALID = out_vld_q;
  assign M_WDATA  = out_reg_q;
  assign M_WKEEP  = out_keep_q;

  // Pack state is a decode of the lane index; cnt_q is the state register.
  always_comb begin
    pack_state = StFill;
    if (cnt_q == '0) begin
      pack_state = StEmpty;
    end else if (cnt_q == LastIdx) begin
      pack_state = StLastLane;
    end
  end

  assign complete = in_hs & ((pack_state == StLastLane) | last_in);

  always_comb begin
    merged = acc_q;
    merged[int'(cnt_q) * WIDTH +: WIDTH] = S_WDATA;
    keep_mask = '0;
    for (int k = 0; k < int'(RATIO); k++) begin
      keep_mask[k] = (k <= int'(cnt_q));
    end
  end

  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_reg_d  = out_reg_q;
    out_keep_d = out_keep_q;
    out_vld_d  = out_vld_q;

    if (out_hs) begin
      out_vld_d = 1'b0;
    end

    if (in_hs) begin
      if (complete) begin
        // A completing beat reloads the slot even while it is being consumed: no bubble.
        out_reg_d  = merged;
        out_keep_d = keep_mask;
        out_vld_d  = 1'b1;
        acc_d      = '0;
        cnt_d      = '0;
      end else begin
        acc_d = merged;
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      out_reg_q  <= '0;
      out_keep_q <= '0;
      out_vld_q  <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      out_reg_q  <= out_reg_d;
      out_keep_q <= out_keep_d;
      out_vld_q  <= out_vld_d;
    end
  end

endmodule

// File: tb/tb_reg_stream_pack.sv
// Directed, table-driven bench for reg_stream_pack (WIDTH=8, RATIO=4) plus a backpressure stream.
module tb_reg_stream_pack;

  localparam int unsigned Width = 8;
  localparam int unsigned Ratio = 4;

  logic                     clk;
  logic                     rst;
  logic                     s_wvalid;
  logic                     s_wready;
  logic [Width-1:0]         s_wdata;
  logic                     s_wlast;
  logic                     m_wvalid;
  logic                     m_wready;
  logic [Width*Ratio-1:0]   m_wdata;
  logic [Ratio-1:0]         m_wkeep;

  int total = 0;
  int bad   = 0;

  reg_stream_pack #(
    .WIDTH(Width),
    .RATIO(Ratio)
  ) dut (
    .CLK_I    (clk),
    .RST_I    (rst),
    .S_WVALID (s_wvalid),
    .S_WREADY (s_wready),
    .S_WDATA  (s_wdata),
    .S_WLAST  (s_wlast),
    .M_WVALID (m_wvalid),
    .M_WREADY (m_wready),
    .M_WDATA  (m_wdata),
    .M_WKEEP  (m_wkeep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row per clock: inputs for the cycle, outputs expected before its rising edge.
  typedef struct {
    logic        rst;
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        mr;
    logic        e_sr;
    logic        e_mv;
    logic        chk_dat;
    logic [31:0] e_md;
    logic [3:0]  e_mk;
  } row_t;

  row_t rows[$];

  task automatic add(input logic r, input logic v, input logic [7:0] d, input logic l,
                     input logic mr, input logic e_sr, input logic e_mv, input logic chk_dat,
                     input logic [31:0] e_md, input logic [3:0] e_mk);
    row_t x;
    x = '{rst: r, v: v, d: d, l: l, mr: mr, e_sr: e_sr, e_mv: e_mv, chk_dat: chk_dat,
          e_md: e_md, e_mk: e_mk};
    rows.push_back(x);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic beat(input logic v, input logic [7:0] d, input logic l, input logic mr);
    add(0, v, d, l, mr, 1, 0, 0, 32'h0, 4'h0);
  endtask

  logic [7:0]  beats[12];
  logic [31:0] words[3];
  int          sent;
  int          got;

  initial begin
    rst      = 1'b1;
    s_wvalid = 1'b0;
    s_wdata  = '0;
    s_wlast  = 1'b0;
    m_wready = 1'b0;

    // Reset row, then full pack 11..44
    add(1, 1, 8'h55, 0, 1, 0, 0, 1, 32'h0, 4'h0);
    beat(1, 8'h11, 0, 1);
    beat(1, 8'h22, 0, 1);
    beat(1, 8'h33, 0, 1);
    beat(1, 8'h44, 0, 1);
    add(0, 0, 8'h00, 0, 1, 1, 1, 1, 32'h44332211, 4'hF);
    beat(0, 8'h00, 0, 1);
    // Streaming 01..08: words four cycles apart, S_WREADY held high
    beat(1, 8'h01, 0, 1);
    beat(1, 8'h02, 0, 1);
    beat(1, 8'h03, 0, 1);
    beat(1, 8'h04, 0, 1);
    add(0, 1, 8'h05, 0, 1, 1, 1, 1, 32'h04030201, 4'hF);
    beat(1, 8'h06, 0, 1);
    beat(1, 8'h07, 0, 1);
    beat(1, 8'h08, 0, 1);
    add(0, 0, 8'h00, 0, 1, 1, 1, 1, 32'h08070605, 4'hF);
    beat(0, 8'h00, 0, 1);
    // Backpressure: five stalled cycles, then drain with a simultaneous non-completing beat
    beat(1, 8'ha1, 0, 1);
    beat(1, 8'ha2, 0, 1);
    beat(1, 8'ha3, 0, 1);
    beat(1, 8'ha4, 0, 1);
    for (int i = 0; i < 5; i++) add(0, 1, 8'hb1, 0, 0, 0, 1, 1, 32'ha4a3a2a1, 4'hF);
    add(0, 1, 8'hb1, 0, 1, 1, 1, 1, 32'ha4a3a2a1, 4'hF);
    beat(1, 8'hb2, 0, 1);
    beat(1, 8'hb3, 0, 1);
    beat(1, 8'hb4, 0, 1);
    add(0, 0, 8'h00, 0, 1, 1, 1, 1, 32'hb4b3b2b1, 4'hF);
    // Mid-reset discards the partial aa/bb word
    beat(1, 8'haa, 0, 1);
    beat(1, 8'hbb, 0, 1);
    add(1, 1, 8'hcc, 0, 1, 0, 0, 0, 32'h0, 4'h0);
    add(0, 1, 8'h01, 0, 1, 1, 0, 1, 32'h0, 4'h0);
    beat(1, 8'h02, 0, 1);
    beat(1, 8'h03, 0, 1);
    beat(1, 8'h04, 0, 1);
    add(0, 0, 8'h00, 0, 1, 1, 1, 1, 32'h04030201, 4'hF);
    beat(0, 8'h00, 0, 1);
    // Reset while a word is pending drops it
    beat(1, 8'hd1, 0, 0);
    beat(1, 8'hd2, 0, 0);
    beat(1, 8'hd3, 0, 0);
    beat(1, 8'hd4, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0, 1, 1, 32'hd4d3d2d1, 4'hF);
    add(1, 0, 8'h00, 0, 0, 0, 1, 1, 32'hd4d3d2d1, 4'hF);
    add(0, 0, 8'h00, 0, 0, 1, 0, 1, 32'h0, 4'h0);
    // S_WLAST on the second beat
    beat(1, 8'hc1, 0, 1);
    beat(1, 8'hc2, 1, 1);
`ifdef REG_STREAM_PACK_LAST_EN
    add(0, 0, 8'h00, 0, 1, 1, 1, 1, 32'h0000c2c1, 4'h3);
    beat(0, 8'h00, 0, 1);
`else
    beat(1, 8'hc3, 0, 1);
    beat(1, 8'hc4, 0, 1);
    add(0, 0, 8'h00, 0, 1, 1, 1, 1, 32'hc4c3c2c1, 4'hF);
`endif

    repeat (2) @(posedge clk);
    #1;

    foreach (rows[i]) begin
      rst      = rows[i].rst;
      s_wvalid = rows[i].v;
      s_wdata  = rows[i].d;
      s_wlast  = rows[i].l;
      m_wready = rows[i].mr;
      #4;
      check("s_wready", i, 32'(s_wready), 32'(rows[i].e_sr));
      check("m_wvalid", i, 32'(m_wvalid), 32'(rows[i].e_mv));
      if (rows[i].chk_dat) begin
        check("m_wdata", i, m_wdata, rows[i].e_md);
        check("m_wkeep", i, 32'(m_wkeep), 32'(rows[i].e_mk));
      end
      @(posedge clk);
      #1;
    end

    // Continuous input under a ready pattern that stalls every third cycle
    rst      = 1'b0;
    s_wvalid = 1'b0;
    s_wlast  = 1'b0;
    m_wready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) beats[i] = 8'(i * 7 + 3);
    for (int w = 0; w < 3; w++) begin
      words[w] = {beats[4*w+3], beats[4*w+2], beats[4*w+1], beats[4*w]};
    end
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 100 && (sent < 12 || got < 3); cyc++) begin
      s_wvalid = (sent < 12);
      s_wdata  = (sent < 12) ? beats[sent] : 8'h00;
      m_wready = (cyc % 3) != 0;
      #4;
      if (s_wvalid && s_wready) sent++;
      if (m_wvalid && m_wready) begin
        check("stream_word", got, m_wdata, words[got]);
        check("stream_keep", got, 32'(m_wkeep), 32'hF);
        got++;
      end
      @(posedge clk);
      #1;
    end
    check("stream_words_seen", 0, 32'(got), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_stream_pack.md
# reg_stream_pack

Width up-converter that packs RATIO consecutive WIDTH-bit beats from a valid/ready stream into one WIDTH*RATIO-bit word. It sits directly downstream of a `reg_fifo_cas` chain and consumes its M_W* stream. It presents a registered, full-throughput valid/ready stream to wide consumers such as memory writers and wide FIFOs. Lane order is little-endian: the first accepted beat lands in bits [WIDTH-1:0].

## Interface
- WIDTH, 8, input beat width in bits; must be ≥1
- RATIO, 4, input beats per output word; must be ≥2
- CLK_I  input  1  single clock; all logic is on the rising edge
- RST_I  input  1  reset, synchronous and active-high
- S_WVALID  input  1  input beat valid
- S_WREADY  output  1  input beat accepted when high together with S_WVALID
- S_WDATA  input  WIDTH  input beat data
- S_WLAST  input  1  final beat of a packet; used only when the macro in Configuration is defined
- M_WVALID  output  1  packed word valid
- M_WREADY  input  1  downstream accept
- M_WDATA  output  WIDTH*RATIO  packed word
- M_WKEEP  output  RATIO  per-lane valid flags; bit k covers M_WDATA[k*WIDTH +: WIDTH]

## Operation
- Input accept is in_hs = S_WVALID & S_WREADY. Output accept is out_hs = M_WVALID & M_WREADY.
- Internal state:
  - acc, a WIDTH*RATIO accumulator
  - cnt, the lane index, $clog2(RATIO) bits, range 0..RATIO-1
  - out_reg, out_keep and out_vld, the registered output slot
- Pack FSM, derived from cnt:
  - EMPTY: cnt=0.
  - FILL: 0<cnt<RATIO-1.
  - LASTLANE: cnt=RATIO-1.
- On in_hs, S_WDATA is written into lane cnt of acc.
  - If the beat completes a word (cnt=RATIO-1), the whole word (acc with the new lane merged) moves to out_reg, out_keep becomes all ones, out_vld is set, acc is cleared to 0, and cnt returns to 0.
  - Otherwise cnt increments and the output slot is unaffected.
- S_WREADY = ~RST_I & (~out_vld | M_WREADY). This is a combinational path from M_WREADY and is documented for integrators.
- Output slot:
  - out_vld clears on out_hs unless a completing beat arrives in the same cycle. In that case the slot reloads and out_vld stays 1, giving back-to-back words with no bubble.
- While M_WVALID=1 and M_WREADY=0, M_WDATA and M_WKEEP hold stable. This is the AXI-style no-retract rule; the block never drops M_WVALID without out_hs.
- Non-completing beats are also stalled while the output is blocked, because of the S_WREADY equation above. This is intentional and keeps acc and out_reg independent.
- Unfilled lanes of M_WDATA are always 0.
- Reset asserted mid-operation discards any partial word in acc and any pending output word, with no flush.

## Timing
- Reset values: M_WVALID=0, M_WDATA=0, M_WKEEP=0, cnt=0, acc=0. S_WREADY=0 while RST_I=1 and S_WREADY=1 in the first cycle after reset.
- Latency: M_WVALID rises in the cycle after the completing in_hs.
- Throughput: one input beat per cycle sustained. With M_WREADY held high, one output word every RATIO cycles.
- Simultaneous in_hs that completes a word and out_hs: the old word is consumed, the new word is loaded, and M_WVALID stays 1.
- Simultaneous non-completing in_hs and out_hs: M_WVALID drops the next cycle and the lane is written.
- cnt wraps from RATIO-1 to 0; it never exceeds RATIO-1.

## Configuration
- Macro: REG_STREAM_PACK_LAST_EN.
- Defined: S_WLAST=1 on in_hs completes the word early at any cnt. Lanes 0..cnt are valid, M_WKEEP = (1<<(cnt+1))-1, upper lanes are 0, and cnt returns to 0. S_WLAST on lane RATIO-1 behaves as a normal completion.
- Undefined: S_WLAST is ignored (the port stays present for a pin-compatible netlist) and M_WKEEP is always all ones whenever M_WVALID=1.

## Test plan
- Full pack (WIDTH=8, RATIO=4, M_WREADY=1): drive beats 0x11, 0x22, 0x33, 0x44 -> one cycle after the 4th accept, M_WDATA=0x44332211, M_WKEEP=4'hF, M_WVALID for 1 cycle.
- Streaming: 8 continuous beats 0x01..0x08 with M_WREADY=1 -> S_WREADY never drops; words 0x04030201 then 0x08070605, 4 cycles apart.
- Backpressure: complete a word, hold M_WREADY=0 for 5 cycles while S_WVALID=1 -> S_WREADY=0, M_WDATA stable, no beats lost. Release M_WREADY -> the next word is correct.
- Simultaneous: M_WREADY=1 in the cycle the next word completes -> M_WVALID stays high and two distinct words are seen on consecutive out_hs.
- Mid-reset: accept 0xAA, 0xBB, pulse RST_I for 1 cycle, then send 0x01..0x04 -> output is 0x04030201 only, and M_WVALID=0 during reset.
- With REG_STREAM_PACK_LAST_EN: beats 0xC1, 0xC2 with S_WLAST on the 2nd -> M_WDATA=0x0000C2C1, M_WKEEP=4'b0011. Without the macro the same stimulus produces no output until 2 more beats arrive.
